// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder cut into STAGES register stages,
// with a valid/ready handshake on both sides. Stage k adds operand slice k plus the
// registered carry of stage k-1, so the longest carry path is one SLICE-bit adder.
// Optional feature: define PIPE_ADD_OVF_EN to add the registered signed-overflow
// output Ovf. When it is undefined there is no Ovf port and no overflow register.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef PIPE_ADD_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int unsigned SLICE = WIDTH / STAGES;
   localparam int unsigned SW    = SLICE + 1;

   // Reject configurations where the operand cannot be cut into equal slices
   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   // Per-stage pipeline registers: beat valid, carry out, partial sum, operands
   logic             valid_q [STAGES];
   logic             carry_q [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];

   // Inputs seen by each stage: the ports for stage 0, the stage below otherwise
   logic             valid_src [STAGES];
   logic             carry_src [STAGES];
   logic [WIDTH-1:0] sum_src   [STAGES];
   logic [WIDTH-1:0] a_src     [STAGES];
   logic [WIDTH-1:0] b_src     [STAGES];

   // Per-stage next values
   logic [SLICE:0]   slice_add [STAGES];
   logic [WIDTH-1:0] sum_n     [STAGES];

   logic             adv;

   // Whole pipe moves together unless the output beat is being held
   assign adv       = !valid_q[STAGES-1] || out_ready;
   assign in_ready  = adv;

   assign out_valid = valid_q[STAGES-1];
   assign Sum       = sum_q[STAGES-1];
   assign Cout      = carry_q[STAGES-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned      LO   = k * SLICE;
      localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}}) << LO;

      // Stage source selection: stage 0 takes the new beat straight from the ports
      if (k == 0) begin : g_src
         assign valid_src[k] = in_valid;
         assign carry_src[k] = Cin;
         assign sum_src[k]   = '0;
         assign a_src[k]     = A;
         assign b_src[k]     = B;
      end else begin : g_src
         assign valid_src[k] = valid_q[k-1];
         assign carry_src[k] = carry_q[k-1];
         assign sum_src[k]   = sum_q[k-1];
         assign a_src[k]     = a_q[k-1];
         assign b_src[k]     = b_q[k-1];
      end

      // One slice of the ripple chain; the carry crosses slices only via a register
      assign slice_add[k] = SW'(a_src[k][LO +: SLICE])
                          + SW'(b_src[k][LO +: SLICE])
                          + SW'(carry_src[k]);

      // Drop the new slice into its position of the partial sum carried along
      assign sum_n[k] = (sum_src[k] & ~MASK)
                      | (WIDTH'(slice_add[k][SLICE-1:0]) << LO);
   end

   // Stage registers: cleared by reset, all shift together on advance, hold on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            sum_q[k]   <= '0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
         end
      end else if (adv) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            valid_q[k] <= valid_src[k];
            carry_q[k] <= slice_add[k][SLICE];
            sum_q[k]   <= sum_n[k];
            a_q[k]     <= a_src[k];
            b_q[k]     <= b_src[k];
         end
      end
   end

`ifdef PIPE_ADD_OVF_EN
   logic ovf_n;
   logic ovf_q;

   // Signed overflow, judged from the sign bits as the final slice completes
   assign ovf_n = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1])
               && (sum_n[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);

   // Overflow flag travels in lockstep with the last stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_n;
      end
   end

   assign Ovf = ovf_q;
`endif

endmodule
